// File: rtl/infer_batch_sequencer.sv
// infer_batch_sequencer: runs a batch of stored test vectors through an
// inference core and records results, latency and timeouts. Option: SEQ_ARGMAX_EN.
module infer_batch_sequencer #(
  parameter int WIDTH         = 16,
  parameter int INPUT_SIZE    = 16,
  parameter int OUTPUT_SIZE   = 5,
  parameter int NUM_TESTS     = 2,
  parameter int RESET_CYCLES  = 2,
  parameter int SETTLE_CYCLES = 10,
  parameter int TIMEOUT       = 1024,
  localparam int NV = NUM_TESTS * INPUT_SIZE,
  localparam int AW = (NV > 1) ? $clog2(NV) : 1,
  localparam int IW = (NUM_TESTS > 1) ? $clog2(NUM_TESTS) : 1,
  localparam int LW = $clog2(TIMEOUT + 1),
  localparam int MW = (OUTPUT_SIZE > 1) ? $clog2(OUTPUT_SIZE) : 1
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                start,
  output logic                                busy,
  output logic                                done,
  input  logic                                vec_wr_en,
  input  logic [AW-1:0]                       vec_wr_addr,
  input  logic [WIDTH-1:0]                    vec_wr_data,
  output logic                                dut_reset,
  output logic                                dut_input_ready,
  output logic [INPUT_SIZE-1:0][WIDTH-1:0]    dut_input_data,
  input  logic                                dut_output_ready,
  input  logic [OUTPUT_SIZE-1:0][WIDTH-1:0]   dut_output_data,
  input  logic [IW-1:0]                       res_rd_addr,
  output logic [OUTPUT_SIZE-1:0][WIDTH-1:0]   res_rd_data,
  output logic [LW-1:0]                       res_rd_lat,
  output logic                                res_rd_tmo,
`ifdef SEQ_ARGMAX_EN
  output logic [MW-1:0]                       res_rd_argmax,
`endif
  output logic [IW-1:0]                       test_idx,
  output logic                                timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_DRST, S_PULSE, S_WAIT,
    S_SETTLE, S_STORE, S_DONE
  } state_t;

  state_t state, nxt;

  logic [31:0]      cnt;
  logic [LW-1:0]    lat;
  logic             tmo;
  logic             last_r, last_s, last_idx, lat_end;
  logic             load;
  logic [IW-1:0]    ld_row;

  logic [WIDTH-1:0]                  vec   [NV];
  logic [OUTPUT_SIZE-1:0][WIDTH-1:0] res   [NUM_TESTS];
  logic [LW-1:0]                     lat_m [NUM_TESTS];
  logic                              tmo_m [NUM_TESTS];
  logic [INPUT_SIZE-1:0][WIDTH-1:0]  cur;

  assign last_r   = (cnt + 32'd1) >= 32'(RESET_CYCLES);
  assign last_s   = (cnt + 32'd1) >= 32'(SETTLE_CYCLES);
  assign last_idx = test_idx >= IW'(NUM_TESTS - 1);
  assign lat_end  = lat == LW'(TIMEOUT - 1);

  assign dut_input_data = cur;

  always_comb begin
    nxt             = state;
    busy            = 1'b0;
    done            = 1'b0;
    dut_reset       = 1'b0;
    dut_input_ready = 1'b0;
    case (state)
      S_IDLE: begin
        dut_reset = 1'b1;
        if (start) nxt = S_DRST;
      end
      S_DRST: begin
        busy      = 1'b1;
        dut_reset = 1'b1;
        if (last_r) nxt = S_PULSE;
      end
      S_PULSE: begin
        busy            = 1'b1;
        dut_input_ready = 1'b1;
        nxt             = S_WAIT;
      end
      S_WAIT: begin
        busy = 1'b1;
        if (dut_output_ready || lat_end) nxt = S_SETTLE;
      end
      S_SETTLE: begin
        busy = 1'b1;
        if (last_s) nxt = S_STORE;
      end
      S_STORE: begin
        busy = 1'b1;
        nxt  = last_idx ? S_DONE : S_DRST;
      end
      S_DONE: begin
        done      = 1'b1;
        dut_reset = 1'b1;
        nxt       = S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      lat         <= '0;
      tmo         <= 1'b0;
      test_idx    <= '0;
      timeout_err <= 1'b0;
    end else begin
      state <= nxt;
      cnt   <= (nxt != state) ? '0 : cnt + 32'd1;
      case (state)
        S_IDLE: begin
          if (start) begin
            test_idx    <= '0;
            timeout_err <= 1'b0;
          end
        end
        S_PULSE: begin
          lat <= '0;
          tmo <= 1'b0;
        end
        S_WAIT: begin
          if (!dut_output_ready) begin
            lat <= lat + LW'(1);
            if (lat_end) begin
              tmo         <= 1'b1;
              timeout_err <= 1'b1;
            end
          end
        end
        S_STORE: begin
          if (!last_idx) test_idx <= test_idx + IW'(1);
        end
        default: ;
      endcase
    end
  end

  // the driven vector is latched on entry to DRST so later writes wait a test
  assign load   = (state == S_IDLE && start)
               || (state == S_STORE && !last_idx);
  assign ld_row = (state == S_STORE) ? test_idx + IW'(1) : '0;

`ifdef SEQ_ARGMAX_EN
  logic [MW-1:0]    amax;
  logic [WIDTH-1:0] best;
  logic [MW-1:0]    am_m [NUM_TESTS];

  always_comb begin
    amax = '0;
    best = dut_output_data[0];
    for (int i = 1; i < OUTPUT_SIZE; i++) begin
      if ($signed(dut_output_data[i]) > $signed(best)) begin
        best = dut_output_data[i];
        amax = MW'(i);
      end
    end
  end
`endif

  // memories are not reset so an aborted batch keeps its data
  always_ff @(posedge clk) begin
    if (vec_wr_en) vec[vec_wr_addr] <= vec_wr_data;
    if (!reset && load) begin
      for (int f = 0; f < INPUT_SIZE; f++)
        cur[f] <= vec[int'(ld_row) * INPUT_SIZE + f];
    end
    if (!reset && state == S_STORE) begin
      res[test_idx]   <= dut_output_data;
      lat_m[test_idx] <= lat;
      tmo_m[test_idx] <= tmo;
`ifdef SEQ_ARGMAX_EN
      am_m[test_idx]  <= amax;
`endif
    end
    res_rd_data <= res[res_rd_addr];
    res_rd_lat  <= lat_m[res_rd_addr];
    res_rd_tmo  <= tmo_m[res_rd_addr];
`ifdef SEQ_ARGMAX_EN
    res_rd_argmax <= am_m[res_rd_addr];
`endif
  end

endmodule

// File: tb/tb_infer_batch_sequencer.sv
// tb_infer_batch_sequencer: stub inference core with programmable latency,
// table-driven batches, hand-written corner sequences and random batches.
module tb_infer_batch_sequencer;

  localparam int W  = 16;
  localparam int IS = 16;
  localparam int OS = 5;
  localparam int NT = 2;
  localparam int RC = 2;
  localparam int SC = 10;
  localparam int TO = 32;
  localparam int AW = $clog2(NT * IS);
  localparam int IW = 1;
  localparam int LW = $clog2(TO + 1);
  localparam int MW = $clog2(OS);

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   start;
  logic                   busy;
  logic                   done;
  logic                   vec_wr_en;
  logic [AW-1:0]          vec_wr_addr;
  logic [W-1:0]           vec_wr_data;
  logic                   dut_reset;
  logic                   dut_input_ready;
  logic [IS-1:0][W-1:0]   dut_input_data;
  logic                   dut_output_ready;
  logic [OS-1:0][W-1:0]   dut_output_data;
  logic [IW-1:0]          res_rd_addr;
  logic [OS-1:0][W-1:0]   res_rd_data;
  logic [LW-1:0]          res_rd_lat;
  logic                   res_rd_tmo;
`ifdef SEQ_ARGMAX_EN
  logic [MW-1:0]          res_rd_argmax;
`endif
  logic [IW-1:0]          test_idx;
  logic                   timeout_err;

  always #5 clk = ~clk;

  infer_batch_sequencer #(
    .WIDTH(W), .INPUT_SIZE(IS), .OUTPUT_SIZE(OS), .NUM_TESTS(NT),
    .RESET_CYCLES(RC), .SETTLE_CYCLES(SC), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .vec_wr_en(vec_wr_en), .vec_wr_addr(vec_wr_addr),
    .vec_wr_data(vec_wr_data), .dut_reset(dut_reset),
    .dut_input_ready(dut_input_ready), .dut_input_data(dut_input_data),
    .dut_output_ready(dut_output_ready),
    .dut_output_data(dut_output_data), .res_rd_addr(res_rd_addr),
    .res_rd_data(res_rd_data), .res_rd_lat(res_rd_lat),
    .res_rd_tmo(res_rd_tmo),
`ifdef SEQ_ARGMAX_EN
    .res_rd_argmax(res_rd_argmax),
`endif
    .test_idx(test_idx), .timeout_err(timeout_err)
  );

  // stub core: echoes inputs, raises ready lat_cfg cycles after its start
  int lat_cfg [NT];
  int s_k;
  int s_lim;
  bit s_act;

  always @(posedge clk) begin
    if (dut_reset) begin
      s_act <= 1'b0;
    end else if (dut_input_ready) begin
      s_act <= 1'b1;
      s_k   <= 0;
      s_lim <= lat_cfg[test_idx];
    end else if (s_act && s_k < 100000) begin
      s_k <= s_k + 1;
    end
  end

  assign dut_output_ready = s_act && (s_k >= s_lim);

  always_comb begin
    dut_output_data = '0;
    for (int j = 0; j < OS; j++) dut_output_data[j] = dut_input_data[j];
  end

  // monitor: cumulative activity counters
  int rdy_tot [NT];
  int rst_tot [NT];
  int done_tot;
  int done_busy;
  int since_rdy;
  int idx_q [$];

  initial begin
    for (int t = 0; t < NT; t++) begin
      rdy_tot[t] = 0;
      rst_tot[t] = 0;
    end
    done_tot  = 0;
    done_busy = 0;
    since_rdy = 1000;
    forever begin
      @(negedge clk);
      if (busy && dut_reset) rst_tot[test_idx]++;
      if (dut_input_ready) begin
        rdy_tot[test_idx]++;
        idx_q.push_back(int'(test_idx));
        since_rdy = 0;
      end else if (since_rdy < 100000) begin
        since_rdy++;
      end
      if (done) begin
        done_tot++;
        if (busy) done_busy++;
      end
    end
  end

  int n_chk;
  int n_fail;
  logic signed [W-1:0] mv [NT][IS];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm,
               $signed(act), $signed(exp));
    end
  endtask

  function automatic int m_lat(input int l);
    return (l < TO) ? l : TO;
  endfunction

  function automatic int m_argmax(input int t);
    int b;
    b = 0;
    for (int j = 1; j < OS; j++) if (mv[t][j] > mv[t][b]) b = j;
    return b;
  endfunction

  task automatic wr_vec(input int t, input int f, input logic [W-1:0] v);
    vec_wr_en   = 1'b1;
    vec_wr_addr = AW'(t * IS + f);
    vec_wr_data = v;
    mv[t][f]    = v;
    @(negedge clk); #1;
    vec_wr_en = 1'b0;
  endtask

  // mode 0 plain, 1 start pulse in WAIT, 2 vector write in WAIT of test 0
  task automatic run_batch(input int l0, input int l1, input int mode,
                           input int el0, input int el1,
                           input bit et0, input bit et1, input bit eerr);
    int d0, q0, r0 [NT], s0 [NT], el [NT], em [NT];
    bit et [NT];
    bit got, inj;
    logic signed [W-1:0] ex [NT][OS];
    logic [W-1:0] newv;
    d0 = done_tot;
    q0 = idx_q.size();
    for (int t = 0; t < NT; t++) begin
      r0[t] = rdy_tot[t];
      s0[t] = rst_tot[t];
      em[t] = m_argmax(t);
      for (int j = 0; j < OS; j++) ex[t][j] = mv[t][j];
    end
    el[0] = el0; el[1] = el1; et[0] = et0; et[1] = et1;
    lat_cfg[0] = l0;
    lat_cfg[1] = l1;
    newv = W'($urandom);
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    got = 0;
    inj = 0;
    for (int c = 0; c < 4000 && !got; c++) begin
      @(negedge clk); #1;
      start     = 1'b0;
      vec_wr_en = 1'b0;
      if (done_tot != d0) begin
        got = 1;
      end else if (mode != 0 && !inj && since_rdy == 3
                   && idx_q.size() == q0 + 1) begin
        inj = 1;
        if (mode == 1) begin
          start = 1'b1;
        end else begin
          vec_wr_en   = 1'b1;
          vec_wr_addr = '0;
          vec_wr_data = newv;
        end
      end
    end
    vec_wr_en = 1'b0;
    if (mode == 2) mv[0][0] = newv;
    chk("done_seen", got, 1);
    chk("busy_at_done", busy, 0);
    chk("timeout_err_at_done", timeout_err, eerr);
    @(negedge clk); #1;
    chk("done_one_cycle", done, 0);
    chk("done_count", done_tot - d0, 1);
    chk("idx_seq_len", idx_q.size() - q0, NT);
    if (idx_q.size() >= q0 + 2) begin
      chk("idx_seq_0", idx_q[q0], 0);
      chk("idx_seq_1", idx_q[q0 + 1], 1);
    end
    for (int t = 0; t < NT; t++) begin
      chk("input_ready_cycles", rdy_tot[t] - r0[t], 1);
      chk("dut_reset_cycles", rst_tot[t] - s0[t], RC);
      res_rd_addr = IW'(t);
      @(negedge clk); #1;
      for (int j = 0; j < OS; j++)
        chk("res_data", $signed(res_rd_data[j]), ex[t][j]);
      chk("res_lat", res_rd_lat, el[t]);
      chk("res_tmo", res_rd_tmo, et[t]);
`ifdef SEQ_ARGMAX_EN
      chk("res_argmax", res_rd_argmax, em[t]);
`endif
    end
  endtask

  typedef struct {
    int l0; int l1; int mode;
    int el0; int el1; bit et0; bit et1; bit err;
  } vec_t;

  vec_t tbl [6];
  int   l0, l1;
  bit   got;

  initial begin
    tbl[0] = '{7,    7,  0, 7,  7,  0, 0, 0};
    tbl[1] = '{1000, 7,  0, 32, 7,  1, 0, 1};
    tbl[2] = '{0,    31, 0, 0,  31, 0, 0, 0};
    tbl[3] = '{32,   5,  0, 32, 5,  1, 0, 1};
    tbl[4] = '{20,   3,  1, 20, 3,  0, 0, 0};
    tbl[5] = '{9,    9,  2, 9,  9,  0, 0, 0};
    n_chk  = 0;
    n_fail = 0;
    lat_cfg[0] = 0;
    lat_cfg[1] = 0;
    reset = 1'b1;
    start = 1'b0;
    vec_wr_en = 1'b0;
    vec_wr_addr = '0;
    vec_wr_data = '0;
    res_rd_addr = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dut_reset", dut_reset, 1);
    chk("rst_input_ready", dut_input_ready, 0);
    chk("rst_test_idx", test_idx, 0);
    chk("rst_timeout_err", timeout_err, 0);
    reset = 1'b0;
    @(negedge clk); #1;
    chk("idle_dut_reset", dut_reset, 1);

    for (int t = 0; t < NT; t++)
      for (int f = 0; f < IS; f++) wr_vec(t, f, W'($urandom));

    for (int i = 0; i < 6; i++)
      run_batch(tbl[i].l0, tbl[i].l1, tbl[i].mode, tbl[i].el0,
                tbl[i].el1, tbl[i].et0, tbl[i].et1, tbl[i].err);

    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < 4; k++)
        wr_vec($urandom_range(0, NT - 1), $urandom_range(0, IS - 1),
               W'($urandom));
      l0 = $urandom_range(0, 40);
      l1 = $urandom_range(0, 40);
      run_batch(l0, l1, 0, m_lat(l0), m_lat(l1), l0 >= TO, l1 >= TO,
                (l0 >= TO) || (l1 >= TO));
    end

`ifdef SEQ_ARGMAX_EN
    wr_vec(0, 0, 16'sd100);
    wr_vec(0, 1, -16'sd5);
    wr_vec(0, 2, 16'sd300);
    wr_vec(0, 3, 16'sd300);
    wr_vec(0, 4, 16'sd2);
    run_batch(7, 7, 0, 7, 7, 0, 0, 0);
    res_rd_addr = '0;
    @(negedge clk); #1;
    chk("argmax_tie", res_rd_argmax, 2);
`endif

    // reset while test 1 waits on the core
    lat_cfg[0] = 4;
    lat_cfg[1] = 1000;
    l0 = done_tot;
    l1 = idx_q.size();
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    got = 0;
    for (int c = 0; c < 500 && !got; c++) begin
      @(negedge clk); #1;
      if (idx_q.size() == l1 + 2 && since_rdy == 5) got = 1;
    end
    chk("reached_wait_1", got, 1);
    chk("wait_1_idx", test_idx, 1);
    reset = 1'b1;
    @(negedge clk); #1;
    reset = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_test_idx", test_idx, 0);
    chk("abort_dut_reset", dut_reset, 1);
    repeat (30) @(negedge clk);
    #1;
    chk("abort_no_done", done_tot - l0, 0);
    res_rd_addr = '0;
    @(negedge clk); #1;
    for (int j = 0; j < OS; j++)
      chk("abort_res0", $signed(res_rd_data[j]), mv[0][j]);
    chk("abort_lat0", res_rd_lat, 4);
    chk("abort_tmo0", res_rd_tmo, 0);
    chk("done_while_busy", done_busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/infer_batch_sequencer.md
INFER_BATCH_SEQUENCER -- requirements
Module: infer_batch_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning bit width of every signed fixed-point input and output element.
REQ-002 SHALL have parameter INPUT_SIZE, default 16, meaning number of input features per test vector.
REQ-003 SHALL have parameter OUTPUT_SIZE, default 5, meaning number of inference outputs per test.
REQ-004 SHALL have parameter NUM_TESTS, default 2, meaning number of test vectors per batch (range 1..166000).
REQ-005 SHALL have parameter RESET_CYCLES, default 2, meaning number of cycles dut_reset is held before each test.
REQ-006 SHALL have parameter SETTLE_CYCLES, default 10, meaning number of cycles waited after dut_output_ready before capture.
REQ-007 SHALL have parameter TIMEOUT, default 1024, meaning maximum wait cycles for dut_output_ready.
REQ-008 SHALL have ports, as name direction width meaning:
- clk  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- start  in  1  begin batch; sampled in IDLE only
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse after the last result is stored
- vec_wr_en  in  1  write one input element into the vector memory
- vec_wr_addr  in  clog2(NUM_TESTS*INPUT_SIZE)  flat element address, test*INPUT_SIZE+feature
- vec_wr_data  in  WIDTH  signed element
- dut_reset  out  1  reset to the inference core
- dut_input_ready  out  1  one-cycle start pulse to the core
- dut_input_data  out  INPUT_SIZE x WIDTH  current test vector
- dut_output_ready  in  1  core result-valid level
- dut_output_data  in  OUTPUT_SIZE x WIDTH  core results
- res_rd_addr  in  clog2(NUM_TESTS)  result index
- res_rd_data  out  OUTPUT_SIZE x WIDTH  stored results; registered, one-cycle read latency
- res_rd_lat  out  clog2(TIMEOUT+1)  stored latency for res_rd_addr
- res_rd_tmo  out  1  stored timeout flag for res_rd_addr
- test_idx  out  clog2(NUM_TESTS)  index of the test in progress
- timeout_err  out  1  sticky: some test in the batch timed out

Function
REQ-009 SHALL implement FSM IDLE -> DRST -> PULSE -> WAIT -> SETTLE -> STORE -> (DRST if more tests, else DONE) -> IDLE.
REQ-010 SHALL in IDLE accept start=1; next state DRST, test_idx=0, timeout_err cleared; start outside IDLE is ignored.
REQ-011 SHALL in DRST assert dut_reset for exactly RESET_CYCLES cycles, with dut_input_data = vector[test_idx], held stable until the next DRST.
REQ-012 SHALL in PULSE assert dut_input_ready for exactly one cycle and clear the latency counter.
REQ-013 SHALL in WAIT increment the latency counter on each cycle dut_output_ready=0; on dut_output_ready=1, go to SETTLE.
REQ-014 SHALL on counter reaching TIMEOUT in WAIT set the per-test timeout flag and timeout_err, then go to SETTLE.
REQ-015 SHALL in SETTLE wait SETTLE_CYCLES cycles, then in STORE capture dut_output_data, the latency and the timeout flag at index test_idx.
REQ-016 SHALL after STORE increment test_idx when test_idx<NUM_TESTS-1; otherwise go to DONE, pulse done for one cycle, and deassert busy in that same cycle.
REQ-017 SHALL accept vec_wr_en in any state; a write to the vector being driven takes effect only at its next DRST.
REQ-018 SHALL NOT modify result memory in any state other than STORE; res_rd_* reads are always legal.

Reset
REQ-019 SHALL on reset=1 enter IDLE with busy=0, done=0, dut_reset=1, dut_input_ready=0, test_idx=0, timeout_err=0, and the latency counter at 0.
REQ-020 SHALL on reset=1 in any state abort the batch with no done pulse; vector and result memory contents are retained.
REQ-021 SHALL keep dut_reset=1 in IDLE.

Configuration
REQ-022 SHALL with macro SEQ_ARGMAX_EN defined add output res_rd_argmax (clog2(OUTPUT_SIZE) bits), the stored index of the largest signed output with lowest index winning ties; without the macro the port and its logic are absent.

Verification
REQ-023 SHALL show: NUM_TESTS=2, stub core asserting output_ready after 7 WAIT cycles and echoing inputs 0..4 -> results equal written vectors, lat=7, tmo=0, one done pulse.
REQ-024 SHALL show: stub never asserting output_ready, TIMEOUT=32 -> test 0 has tmo=1 and lat=32, test 1 still runs, timeout_err=1 at done.
REQ-025 SHALL show: start pulsed during WAIT -> no restart, test_idx sequence 0,1 unchanged.
REQ-026 SHALL show: reset in WAIT of test 1 -> IDLE next cycle, busy=0, no done, result 0 retained.
REQ-027 SHALL show: dut_input_ready high exactly 1 cycle per test and dut_reset high exactly RESET_CYCLES=2 cycles per test.
REQ-028 SHALL show, with SEQ_ARGMAX_EN: outputs {100,-5,300,300,2} -> argmax=2.
